// File: rtl/sram_b_fifo_pkg.sv
// Shared constants and types for the sram_b stream FIFO controller.
// The SRAM geometry here matches the 64x8 1w:1r sram_b macro.
package sram_b_fifo_pkg;

  localparam int SRAM_B_AW    = 6;
  localparam int SRAM_B_DW    = 8;
  localparam int SRAM_B_DEPTH = 64;
  localparam int SRAM_B_OBD   = 2;

  typedef logic [SRAM_B_AW-1:0] sram_b_addr_t;
  typedef logic [SRAM_B_AW:0]   sram_b_cnt_t;

endpackage

// File: rtl/sram_b_fifo_obuf.sv
// Two-entry flop FIFO that absorbs SRAM read data; entry 0 is always the head,
// so the head data comes straight from a flop.
module sram_b_fifo_obuf
  import sram_b_fifo_pkg::*;
#(
  parameter int DW = SRAM_B_DW
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);

  logic [DW-1:0] ent0_r, ent1_r;
  logic [1:0]    cnt_r;
  logic [DW-1:0] ent0_nxt_s, ent1_nxt_s;
  logic [1:0]    cnt_nxt_s;

  // Next-state of the shift-style buffer; a pop with a push lands data behind the new head
  always_comb begin
    ent0_nxt_s = ent0_r;
    ent1_nxt_s = ent1_r;
    cnt_nxt_s  = cnt_r;
    case ({push, pop})
      2'b10: begin
        cnt_nxt_s = cnt_r + 2'd1;
        if (cnt_r == 2'd0) begin
          ent0_nxt_s = din;
        end else begin
          ent1_nxt_s = din;
        end
      end
      2'b01: begin
        cnt_nxt_s  = cnt_r - 2'd1;
        ent0_nxt_s = ent1_r;
      end
      2'b11: begin
        if (cnt_r == 2'd1) begin
          ent0_nxt_s = din;
        end else begin
          ent0_nxt_s = ent1_r;
          ent1_nxt_s = din;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Buffer storage and occupancy registers
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ent0_r <= {DW{1'b0}};
      ent1_r <= {DW{1'b0}};
      cnt_r  <= 2'd0;
    end else begin
      ent0_r <= ent0_nxt_s;
      ent1_r <= ent1_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign head = ent0_r;
  assign cnt  = cnt_r;

endmodule

// File: rtl/sram_b_stream_fifo.sv
// Valid/ready stream FIFO built on one 64x8 1w:1r SRAM plus a 2-entry output buffer
// that hides the 1-cycle SRAM read latency; total capacity 66 words.
module sram_b_stream_fifo
  import sram_b_fifo_pkg::*;
#(
  parameter int AW  = SRAM_B_AW,
  parameter int DW  = SRAM_B_DW,
  parameter int OBD = SRAM_B_OBD
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          CE0,
  output logic [AW-1:0] A0,
  output logic [DW-1:0] D0,
  output logic          WE0,
  output logic [DW-1:0] WEM0,
  output logic          CE1,
  output logic [AW-1:0] A1,
  input  logic [DW-1:0] Q1
);

  localparam logic [AW:0]   SCNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   scnt_r, count_r;
  logic          inflight_r;

  logic          push_s, pop_s, issue_s;
  logic [1:0]    ob_cnt_s;
  logic [DW-1:0] ob_head_s;
  logic [2:0]    ob_need_s, ob_lim_s;
  logic [AW:0]   scnt_nxt_s, count_nxt_s;

  assign in_ready  = (scnt_r != SCNT_FULL);
  assign out_valid = (ob_cnt_s != 2'd0);
  assign out_data  = ob_head_s;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // A read may issue only if the word it returns is guaranteed a buffer slot
  assign ob_need_s = {1'b0, ob_cnt_s} + {2'b00, inflight_r};
  assign ob_lim_s  = 3'(OBD) + {2'b00, pop_s};
  assign issue_s   = (scnt_r != {(AW+1){1'b0}}) & (ob_need_s < ob_lim_s);

  assign CE0  = push_s;
  assign WE0  = push_s;
  assign A0   = wr_ptr_r;
  assign D0   = in_data;
  assign WEM0 = {DW{push_s}};
  assign CE1  = issue_s;
  assign A1   = rd_ptr_r;
  assign count = count_r;

  // SRAM occupancy and total occupancy updates
  always_comb begin
    scnt_nxt_s  = scnt_r;
    count_nxt_s = count_r;
    case ({push_s, issue_s})
      2'b10:   scnt_nxt_s = scnt_r + CNT_ONE;
      2'b01:   scnt_nxt_s = scnt_r - CNT_ONE;
      default: scnt_nxt_s = scnt_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers wrap naturally; scnt alone tells full from empty
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      scnt_r     <= {(AW+1){1'b0}};
      count_r    <= {(AW+1){1'b0}};
      inflight_r <= 1'b0;
    end else begin
      wr_ptr_r   <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r   <= issue_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      scnt_r     <= scnt_nxt_s;
      count_r    <= count_nxt_s;
      inflight_r <= issue_s;
    end
  end

  sram_b_fifo_obuf #(.DW(DW)) u_obuf (
    .CLK  (CLK),
    .rst  (rst),
    .push (inflight_r),
    .din  (Q1),
    .pop  (pop_s),
    .head (ob_head_s),
    .cnt  (ob_cnt_s)
  );

endmodule

// File: tb/tb_sram_b_stream_fifo.sv
// Self-checking bench for sram_b_stream_fifo with a behavioural 64x8 SRAM and a
// queue-based reference model of the 66-word FIFO.
module tb_sram_b_stream_fifo;

  logic       CLK = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [6:0] count;
  logic       CE0, WE0, CE1;
  logic [5:0] A0, A1;
  logic [7:0] D0, WEM0, Q1;

  logic [7:0] mem [64];
  logic [7:0] q1_r;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  int wr_tot, rd_tot, sent, first_pop, last_pop;
  bit push_s, pop_s, ce1_seen;
  logic [7:0] exp_d;

  always #5 CLK = ~CLK;

  // Behavioural SRAM: synchronous write, one-cycle read latency
  always @(posedge CLK) begin
    if (CE0 && WE0) mem[A0] <= D0 & WEM0;
    if (CE1) q1_r <= mem[A1];
  end
  assign Q1 = q1_r;

  sram_b_stream_fifo dut (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate handshakes at negedge against the model, then check count
  task automatic cycle();
    @(negedge CLK);
    push_s   = in_valid && in_ready;
    pop_s    = out_valid && out_ready;
    ce1_seen = CE1;
    chk("ce0", CE0, push_s);
    chk("we0", WE0, push_s);
    chk("wem0", WEM0, push_s ? 8'hFF : 8'h00);
    chk("in_ready", in_ready, (wr_tot - rd_tot) != 64);
    if (push_s) begin
      chk("a0", A0, wr_tot % 64);
      chk("d0", D0, in_data);
    end
    if (CE1) begin
      chk("a1", A1, rd_tot % 64);
      chk("ce1_occ", (wr_tot - rd_tot) > 0, 1);
    end
    if (CE0 && CE1) chk("addr_conflict", A0 != A1, 1);
    if (q.size() == 0) chk("ov_empty", out_valid, 0);
    if (pop_s && q.size() > 0) begin
      exp_d = q.pop_front();
      chk("data", out_data, exp_d);
    end
    if (push_s) begin
      q.push_back(in_data);
      wr_tot++;
    end
    if (CE1) rd_tot++;
    @(posedge CLK);
    #1;
    chk("count", count, q.size());
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && q.size() > 0; i++) cycle();
    chk(tag, q.size(), 0);
  endtask

  initial begin
    wr_tot = 0; rd_tot = 0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_ce0", CE0, 0);
    chk("rst_ce1", CE1, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge CLK);
    rst = 1'b1;
    @(posedge CLK);
    #1;

    // 1: single word latency
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    chk("t1_ce0", CE0, 1);
    cycle();
    in_valid = 1'b0;
    first_pop = 1;
    while (out_valid !== 1'b1 && first_pop < 10) begin
      cycle();
      first_pop++;
    end
    chk("t1_latency", first_pop, 3);
    chk("t1_head", out_data, 8'hA5);
    cycle();
    chk("t1_count0", count, 0);

    // 2: fill to 66 with the consumer stalled
    out_ready = 1'b0; sent = 0;
    for (int i = 0; i < 200 && sent < 66; i++) begin
      in_valid = 1'b1; in_data = 8'(sent);
      cycle();
      if (push_s) sent++;
    end
    chk("t2_sent", sent, 66);
    chk("t2_full_ready", in_ready, 0);
    chk("t2_count66", count, 66);
    chk("t2_out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hEE;
      cycle();
      chk("t2_refused", push_s, 0);
    end

    // 5: push and pop together while full
    in_valid = 1'b1; in_data = 8'd200; out_ready = 1'b1;
    #1;
    chk("t5_in_ready_lo", in_ready, 0);
    chk("t5_ce1", CE1, 1);
    cycle();
    chk("t5_in_ready_hi", in_ready, 1);
    for (int k = 1; k < 6; k++) begin
      in_data = 8'(200 + k);
      cycle();
    end
    drain("t2_drain");

    // 3: sustained one word per cycle with pointer wrap
    out_ready = 1'b1; sent = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 210; i++) begin
      in_valid = (sent < 200); in_data = 8'(sent * 7 + 3);
      cycle();
      if (push_s) sent++;
      if (pop_s) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
    end
    chk("t3_sent", sent, 200);
    chk("t3_first_pop", first_pop, 3);
    chk("t3_last_pop", last_pop, 202);

    // 4: random traffic
    sent = 0;
    for (int i = 0; i < 60000 && sent < 10000; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); in_data = 8'($urandom);
      cycle();
      chk("t4_count_max", count <= 7'd66, 1);
      if (push_s) sent++;
    end
    chk("t4_sent", sent, 10000);
    drain("t4_drain");

    // 6: reset while a read is in flight
    out_ready = 1'b0; ce1_seen = 1'b0;
    for (int i = 0; i < 10 && !ce1_seen; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + i);
      cycle();
    end
    chk("t6_ce1_seen", ce1_seen, 1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_count", count, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_ce0", CE0, 0);
    chk("t6_ce1", CE1, 0);
    q.delete(); wr_tot = 0; rd_tot = 0;
    @(negedge CLK);
    rst = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) cycle();
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    cycle();
    chk("t6_push", push_s, 1);
    drain("t6_drain");
    chk("t6_count0", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
